conv_tile_controller: RTL and testbench

//  Sequencer for three_by_three_systolic: 4x4 image tile, 3x3 filter, 2x2 output.

---
 rtl/conv_tile_controller.sv | 173 +++++++++++++++++
 tb/tb_conv_tile_controller.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_tile_controller.sv
`default_nettype none
// ============================================================================
// conv_tile_controller : loads a 3x3 filter and a 4x4 tile, runs the systolic
// array, and streams out the 2x2 result. Option macro: CONV_FILTER_REUSE_EN.
// Revision: 1.0
// ============================================================================
module conv_tile_controller #(
   parameter int DATA_W  = 8,
   parameter int LATENCY = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  reuse_filt,
   output logic                  busy,
   output logic                  done,
   input  logic [DATA_W-1:0]     in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_W-1:0]     out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  sa_rst,
   output logic [16*DATA_W-1:0]  sa_img,
   output logic [9*DATA_W-1:0]   sa_filt,
   input  logic [4*DATA_W-1:0]   sa_out
);

   localparam int LAT_W = $clog2(LATENCY + 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_LOAD_FILT = 3'd1;
   localparam logic [2:0] S_LOAD_IMG  = 3'd2;
   localparam logic [2:0] S_COMPUTE   = 3'd3;
   localparam logic [2:0] S_DRAIN     = 3'd4;

   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATENCY);

   logic [2:0]             state_q, state_d;
   logic [4:0]             idx_q, idx_d;
   logic [LAT_W-1:0]       lat_q, lat_d;
   logic [1:0]             k_q, k_d;
   logic [9*DATA_W-1:0]    filt_q, filt_d;
   logic [16*DATA_W-1:0]   img_q, img_d;
   logic [4*DATA_W-1:0]    res_q, res_d;
   logic                   done_q, done_d;
   logic                   reuse_ok;

`ifdef CONV_FILTER_REUSE_EN
   logic                   filt_loaded_q, filt_loaded_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt_loaded_q <= 1'b0;
      end else begin
         filt_loaded_q <= filt_loaded_d;
      end
   end

   assign reuse_ok = reuse_filt & filt_loaded_q;
`else
   logic                   unused_reuse_filt;

   assign unused_reuse_filt = reuse_filt;
   assign reuse_ok          = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      lat_d   = lat_q;
      k_d     = k_q;
      filt_d  = filt_q;
      img_d   = img_q;
      res_d   = res_q;
      done_d  = 1'b0;
`ifdef CONV_FILTER_REUSE_EN
      filt_loaded_d = filt_loaded_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               idx_d   = 5'd0;
               state_d = reuse_ok ? S_LOAD_IMG : S_LOAD_FILT;
            end
         end
         S_LOAD_FILT: begin
            if (in_valid) begin
               filt_d[DATA_W*int'(idx_q) +: DATA_W] = in_data;
               if (idx_q == 5'd8) begin
                  idx_d   = 5'd0;
                  state_d = S_LOAD_IMG;
`ifdef CONV_FILTER_REUSE_EN
                  filt_loaded_d = 1'b1;
`endif
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end
         S_LOAD_IMG: begin
            if (in_valid) begin
               img_d[DATA_W*int'(idx_q) +: DATA_W] = in_data;
               if (idx_q == 5'd15) begin
                  idx_d   = 5'd0;
                  lat_d   = '0;
                  state_d = S_COMPUTE;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end
         S_COMPUTE: begin
            // lat_q==0 is the array reset cycle; 1..LATENCY run the array
            if (lat_q == LAT_LAST) begin
               res_d   = sa_out;
               lat_d   = '0;
               k_d     = 2'd0;
               state_d = S_DRAIN;
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end
         S_DRAIN: begin
            if (out_ready) begin
               if (k_q == 2'd3) begin
                  k_d     = 2'd0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  k_d = k_q + 2'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= 5'd0;
         lat_q   <= '0;
         k_q     <= 2'd0;
         filt_q  <= '0;
         img_q   <= '0;
         res_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         lat_q   <= lat_d;
         k_q     <= k_d;
         filt_q  <= filt_d;
         img_q   <= img_d;
         res_q   <= res_d;
         done_q  <= done_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign in_ready  = (state_q == S_LOAD_FILT) || (state_q == S_LOAD_IMG);
   assign out_valid = (state_q == S_DRAIN);
   assign out_data  = res_q[DATA_W*int'(k_q) +: DATA_W];
   assign sa_rst    = !((state_q == S_COMPUTE) && (lat_q != '0));
   assign sa_img    = img_q;
   assign sa_filt   = filt_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_tile_controller.sv
`default_nettype none
// ============================================================================
// tb_conv_tile_controller : scoreboard bench with a behavioural array model.
// Revision: 1.0
// ============================================================================
module tb_conv_tile_controller;

   localparam int DATA_W  = 8;
   localparam int LATENCY = 24;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  start;
   logic                  reuse_filt;
   logic                  busy;
   logic                  done;
   logic [DATA_W-1:0]     in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_W-1:0]     out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  sa_rst;
   logic [16*DATA_W-1:0]  sa_img;
   logic [9*DATA_W-1:0]   sa_filt;
   logic [4*DATA_W-1:0]   sa_out;

   always #5 clk = ~clk;

   conv_tile_controller #(.DATA_W(DATA_W), .LATENCY(LATENCY)) dut (
      .clk(clk), .rst(rst), .start(start), .reuse_filt(reuse_filt),
      .busy(busy), .done(done),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .sa_rst(sa_rst), .sa_img(sa_img), .sa_filt(sa_filt), .sa_out(sa_out)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // valid 2D correlation, results truncated to DATA_W
   function automatic logic [4*DATA_W-1:0] conv(input logic [16*DATA_W-1:0] img,
                                                input logic [9*DATA_W-1:0] f);
      logic [4*DATA_W-1:0] r;
      logic [31:0]         acc;
      r = '0;
      for (int orow = 0; orow < 2; orow++) begin
         for (int ocol = 0; ocol < 2; ocol++) begin
            acc = 0;
            for (int i = 0; i < 3; i++) begin
               for (int j = 0; j < 3; j++) begin
                  acc = acc + 32'(img[DATA_W*(4*(orow+i)+ocol+j) +: DATA_W]) *
                              32'(f[DATA_W*(3*i+j) +: DATA_W]);
               end
            end
            r[DATA_W*(2*orow+ocol) +: DATA_W] = acc[DATA_W-1:0];
         end
      end
      return r;
   endfunction

   // array model: result only valid from the LATENCY-th cycle out of reset
   int low_run  = 0;
   int lat_seen = 0;
   always @(posedge clk) begin
      if (sa_rst) begin
         if (low_run != 0) lat_seen = low_run;
         low_run = 0;
      end else begin
         low_run = low_run + 1;
      end
   end
   assign sa_out = (!sa_rst && low_run >= LATENCY-1) ? conv(sa_img, sa_filt) : {4{8'hEE}};

   logic [31:0] exp_q[$];
   int beat_cnt = 0;
   int done_cnt = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (in_valid && in_ready) beat_cnt++;
         if (done) done_cnt++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("out_extra_beat", 32'(exp_q.size()), 32'd1);
            else check("out_data", 32'(out_data), exp_q.pop_front());
         end
      end
   end

   logic [DATA_W-1:0]   stream[25];
   logic [9*DATA_W-1:0] kept_filt = '0;
   bit                  filt_loaded_m = 1'b0;

   localparam logic [DATA_W-1:0] W0[9]  = '{3,2,0,2,0,1,3,1,1};
   localparam logic [DATA_W-1:0] P0[16] = '{9,8,2,6,0,4,1,6,4,10,1,1,2,2,9,9};

   task automatic load_base();
      for (int i = 0; i < 9; i++)  stream[i]   = W0[i];
      for (int i = 0; i < 16; i++) stream[9+i] = P0[i];
   endtask

   task automatic drive_in(input int first, input int n, input bit gaps, input bit spam);
      int  i = 0;
      int  cyc = 0;
      bit  tog = 1'b1;
      bit  hs;
      while (i < n && cyc < 400) begin
         in_data  = stream[first+i];
         in_valid = gaps ? tog : 1'b1;
         tog      = ~tog;
         start    = spam && (i == 12);
         @(negedge clk);
         hs = in_valid && in_ready;
         @(posedge clk); #1;
         start = 1'b0;
         if (hs) i++;
         cyc++;
      end
      in_valid = 1'b0;
      if (i < n) check("in_timeout", 32'(i), 32'(n));
   endtask

   task automatic wait_out_valid();
      int c = 0;
      @(negedge clk);
      while (!out_valid && c < 200) begin
         @(negedge clk);
         c++;
      end
      if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
   endtask

   task automatic run_job(input bit gaps, input bit bp, input bit spam, input bit reuse,
                          input bit spec_vals);
      int b0, d0, nbeats, c;
      bit use_reuse;
      logic [16*DATA_W-1:0] img;
      logic [9*DATA_W-1:0]  f;
      logic [4*DATA_W-1:0]  r;
`ifdef CONV_FILTER_REUSE_EN
      use_reuse = reuse && filt_loaded_m;
`else
      use_reuse = 1'b0;
`endif
      nbeats = use_reuse ? 16 : 25;
      if (use_reuse) begin
         f = kept_filt;
         for (int i = 0; i < 16; i++) img[DATA_W*i +: DATA_W] = stream[i];
      end else begin
         for (int i = 0; i < 9; i++)  f[DATA_W*i +: DATA_W]   = stream[i];
         for (int i = 0; i < 16; i++) img[DATA_W*i +: DATA_W] = stream[9+i];
      end
      kept_filt     = f;
      filt_loaded_m = 1'b1;
      if (spec_vals) begin
         exp_q.push_back(32'd67); exp_q.push_back(32'd74);
         exp_q.push_back(32'd34); exp_q.push_back(32'd59);
      end else begin
         r = conv(img, f);
         for (int q = 0; q < 4; q++) exp_q.push_back(32'(r[DATA_W*q +: DATA_W]));
      end
      b0 = beat_cnt;
      d0 = done_cnt;
      out_ready  = !bp;
      start      = 1'b1;
      reuse_filt = reuse;
      @(posedge clk); #1;
      start      = 1'b0;
      reuse_filt = 1'b0;
      if (reuse) begin
         drive_in(0, 16, gaps, 1'b0);
         @(negedge clk);
         check("reuse_in_ready", 32'(in_ready), use_reuse ? 32'd0 : 32'd1);
         @(posedge clk); #1;
         if (!use_reuse) drive_in(16, 9, gaps, 1'b0);
      end else begin
         drive_in(0, nbeats, gaps, spam);
      end
      @(negedge clk);
      check("in_ready_after_load", 32'(in_ready), 32'd0);
      check("beats_consumed", 32'(beat_cnt - b0), 32'(nbeats));
      check("sa_filt", sa_filt, f);
      check("sa_img_lo", sa_img[63:0], img[63:0]);
      check("sa_img_hi", sa_img[127:64], img[127:64]);
      wait_out_valid();
      if (bp) begin
         for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_hold_data", 32'(out_data), exp_q.size() > 0 ? exp_q[0] : 32'hFFFF);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
         end
         @(posedge clk); #1;
         out_ready = 1'b1;
      end
      if (spam) begin
         @(posedge clk); #1; start = 1'b1;
         @(posedge clk); #1; start = 1'b0;
      end
      c = 0;
      while (done_cnt == d0 && c < 200) begin
         @(negedge clk);
         c++;
      end
      check("done_seen", 32'(done_cnt - d0), 32'd1);
      check("out_valid_after_done", 32'(out_valid), 32'd0);
      repeat (6) @(negedge clk);
      check("busy_idle", 32'(busy), 32'd0);
      check("done_once", 32'(done_cnt - d0), 32'd1);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      check("compute_latency", 32'(lat_seen), 32'(LATENCY));
      check("sa_rst_idle", 32'(sa_rst), 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      int c;
      rst = 1'b1; start = 1'b0; reuse_filt = 1'b0;
      in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_sa_rst", 32'(sa_rst), 32'd1);
      check("rst_sa_filt", sa_filt[31:0], 32'd0);
      check("rst_sa_img", sa_img[31:0], 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      load_base();
      run_job(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);   // basic tile
      run_job(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);   // input gaps
      run_job(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);   // output backpressure
      run_job(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);   // start pulses ignored

      for (int i = 0; i < 25; i++) stream[i] = DATA_W'($urandom_range(0, 255));
      run_job(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      // reset in the middle of COMPUTE
      load_base();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      drive_in(0, 25, 1'b0, 1'b0);
      c = 0;
      @(negedge clk);
      while (sa_rst && c < 50) begin
         @(negedge clk);
         c++;
      end
      check("compute_started", 32'(sa_rst), 32'd0);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_sa_rst", 32'(sa_rst), 32'd1);
      check("midrst_sa_img", sa_img[63:0], 64'd0);
      check("midrst_sa_filt", sa_filt[31:0], 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      filt_loaded_m = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_job(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // filter reuse: pixels first, trailing weights only consumed without the option
      for (int i = 0; i < 16; i++) stream[i]    = P0[i];
      for (int i = 0; i < 9; i++)  stream[16+i] = W0[i];
`ifdef CONV_FILTER_REUSE_EN
      run_job(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
`else
      run_job(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got %0d checks, required completion", n_checks);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
